// File: rtl/fulladder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fulladder_pkg
// Description : Shared core indices, core coding styles and the 2-of-3 vote.
// Revision    : 1.0 - initial release
// ============================================================================
package fulladder_pkg;

    localparam int CORE_GATE = 0;
    localparam int CORE_BEH  = 1;
    localparam int CORE_DF   = 2;
    localparam int NUM_CORES = 3;

    typedef enum logic [1:0] {
        STYLE_GATE = 2'd0,
        STYLE_BEH  = 2'd1,
        STYLE_DF   = 2'd2
    } core_style_e;

    function automatic logic maj3(input logic [NUM_CORES-1:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fa_core.sv
`default_nettype none
// ============================================================================
// Module      : fa_core
// Description : 1-bit full adder; STYLE picks gate, behavioural or dataflow coding.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_core
    import fulladder_pkg::*;
#(
    parameter core_style_e STYLE = STYLE_GATE
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    generate
        if (STYLE == STYLE_GATE) begin : g_gate
            logic w_ab_xor;
            logic w_ab_and;
            logic w_c_prop;
            xor u_xor_ab  (w_ab_xor, a, b);
            xor u_xor_sum (sum, w_ab_xor, cin);
            and u_and_ab  (w_ab_and, a, b);
            and u_and_cp  (w_c_prop, cin, w_ab_xor);
            or  u_or_cout (cout, w_ab_and, w_c_prop);
        end else if (STYLE == STYLE_BEH) begin : g_beh
            // Truth-table form keeps this core independent of the XOR/AND structure.
            always_comb begin
                sum  = 1'b0;
                cout = 1'b0;
                case ({a, b, cin})
                    3'b001, 3'b010, 3'b100: sum = 1'b1;
                    3'b011, 3'b101, 3'b110: cout = 1'b1;
                    3'b111: begin
                        sum  = 1'b1;
                        cout = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin : g_df
            assign sum  = a ^ b ^ cin;
            assign cout = (a & b) | (cin & (a ^ b));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fulladder_voter.sv
`default_nettype none
// ============================================================================
// Module      : fulladder_voter
// Description : Registered TMR full adder with 2-of-3 vote and mismatch tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module fulladder_voter
    import fulladder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 a,
    input  logic                 b,
    input  logic                 cin,
    input  logic [NUM_CORES-1:0] fault_inj,
    input  logic                 clear_err,
    output logic                 out_valid,
    output logic                 sum,
    output logic                 cout,
    output logic [NUM_CORES-1:0] core_sum,
    output logic [NUM_CORES-1:0] core_cout,
    output logic                 mismatch,
    output logic                 mismatch_sticky,
    output logic [CNT_W-1:0]     mismatch_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CORES-1:0] w_raw_sum;
    logic [NUM_CORES-1:0] w_core_sum;
    logic [NUM_CORES-1:0] w_core_cout;
    logic                 w_mismatch;

    logic                 r_out_valid;
    logic                 r_sum;
    logic                 r_cout;
    logic [NUM_CORES-1:0] r_core_sum;
    logic [NUM_CORES-1:0] r_core_cout;
    logic                 r_mismatch;
    logic                 r_sticky;
    logic [CNT_W-1:0]     r_cnt;

    fa_core #(.STYLE(STYLE_GATE)) u_core_gate (
        .a(a), .b(b), .cin(cin), .sum(w_raw_sum[CORE_GATE]), .cout(w_core_cout[CORE_GATE])
    );
    fa_core #(.STYLE(STYLE_BEH)) u_core_beh (
        .a(a), .b(b), .cin(cin), .sum(w_raw_sum[CORE_BEH]), .cout(w_core_cout[CORE_BEH])
    );
    fa_core #(.STYLE(STYLE_DF)) u_core_df (
        .a(a), .b(b), .cin(cin), .sum(w_raw_sum[CORE_DF]), .cout(w_core_cout[CORE_DF])
    );

    generate
        for (genvar i = 0; i < NUM_CORES; i++) begin : g_fault
            assign w_core_sum[i] = w_raw_sum[i] ^ fault_inj[i];
        end
    endgenerate

    // Disagreement means a vector is neither all-zero nor all-one.
    assign w_mismatch = ~((&w_core_sum)  | ~(|w_core_sum))
                      | ~((&w_core_cout) | ~(|w_core_cout));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= 1'b0;
            r_cout      <= 1'b0;
            r_core_sum  <= '0;
            r_core_cout <= '0;
            r_mismatch  <= 1'b0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_core_sum  <= w_core_sum;
                r_core_cout <= w_core_cout;
                r_sum       <= maj3(w_core_sum);
                r_cout      <= maj3(w_core_cout);
                r_mismatch  <= w_mismatch;
            end
            // A clear wins over a mismatch on the same edge.
            if (clear_err) begin
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end else if (in_valid && w_mismatch) begin
                r_sticky <= 1'b1;
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign sum             = r_sum;
    assign cout            = r_cout;
    assign core_sum        = r_core_sum;
    assign core_cout       = r_core_cout;
    assign mismatch        = r_mismatch;
    assign mismatch_sticky = r_sticky;
    assign mismatch_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fulladder_voter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fulladder_voter
// Description : Self-checking bench: vector table, corner sequences, random vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fulladder_voter;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       cin;
        logic [2:0] fault;
        logic       clear;
        logic       e_sum;
        logic       e_cout;
        logic [2:0] e_cs;
        logic [2:0] e_cc;
        logic       e_mis;
        logic       e_st;
        logic [7:0] e_cnt;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             cin;
    logic [2:0]       fault_inj;
    logic             clear_err;
    logic             out_valid;
    logic             sum;
    logic             cout;
    logic [2:0]       core_sum;
    logic [2:0]       core_cout;
    logic             mismatch;
    logic             mismatch_sticky;
    logic [CNT_W-1:0] mismatch_cnt;

    int n_cmp;
    int n_fail;

    // Reference model state
    logic       m_ov;
    logic       m_sum;
    logic       m_cout;
    logic [2:0] m_cs;
    logic [2:0] m_cc;
    logic       m_mis;
    logic       m_st;
    int         m_cnt;

    vec_t tbl [13];

    fulladder_voter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .fault_inj(fault_inj), .clear_err(clear_err), .out_valid(out_valid),
        .sum(sum), .cout(cout), .core_sum(core_sum), .core_cout(core_cout),
        .mismatch(mismatch), .mismatch_sticky(mismatch_sticky), .mismatch_cnt(mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ia, input logic ib, input logic ic,
                                input logic [2:0] f, input logic clr,
                                input logic es, input logic ec, input logic [2:0] ecs,
                                input logic [2:0] ecc, input logic em, input logic est,
                                input logic [7:0] ecnt);
        vec_t v;
        v = {ia, ib, ic, f, clr, es, ec, ecs, ecc, em, est, ecnt};
        return v;
    endfunction

    // Model: arithmetic add, per-core inversion, majority by population count.
    task automatic model_clock(input logic v, input logic ia, input logic ib, input logic ic,
                               input logic [2:0] f, input logic clr);
        int         total;
        logic [2:0] cs;
        logic [2:0] cc;
        logic       dis;
        total = int'(ia) + int'(ib) + int'(ic);
        cs  = {3{total[0]}} ^ f;
        cc  = {3{total[1]}};
        dis = ($countones(cs) != 0 && $countones(cs) != 3);
        m_ov = v;
        if (v) begin
            m_cs   = cs;
            m_cc   = cc;
            m_sum  = ($countones(cs) >= 2);
            m_cout = total[1];
            m_mis  = dis;
        end
        if (clr) begin
            m_st  = 1'b0;
            m_cnt = 0;
        end else if (v && dis) begin
            m_st  = 1'b1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".sum"},       32'(sum),       32'(m_sum));
        check({tag, ".cout"},      32'(cout),      32'(m_cout));
        check({tag, ".core_sum"},  32'(core_sum),  32'(m_cs));
        check({tag, ".core_cout"}, 32'(core_cout), 32'(m_cc));
        check({tag, ".mismatch"},  32'(mismatch),  32'(m_mis));
        check({tag, ".sticky"},    32'(mismatch_sticky), 32'(m_st));
        check({tag, ".cnt"},       32'(mismatch_cnt),    32'(m_cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        fault_inj = 3'b000; clear_err = 1'b0;

        //             a  b  c  fault   clr sum co cs      cc      mis st cnt
        tbl[0]  = mk(1, 0, 0, 3'b000, 0,  1, 0, 3'b111, 3'b000, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 3'b000, 0,  0, 1, 3'b000, 3'b111, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 3'b000, 0,  0, 0, 3'b000, 3'b000, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 3'b000, 0,  1, 0, 3'b111, 3'b000, 0, 0, 0);
        tbl[4]  = mk(1, 0, 1, 3'b000, 0,  0, 1, 3'b000, 3'b111, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 3'b000, 0,  1, 1, 3'b111, 3'b111, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 3'b000, 0,  1, 0, 3'b111, 3'b000, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 3'b000, 0,  0, 1, 3'b000, 3'b111, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 3'b010, 0,  1, 0, 3'b101, 3'b000, 1, 1, 1);
        tbl[9]  = mk(1, 0, 0, 3'b000, 1,  1, 0, 3'b111, 3'b000, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 3'b011, 0,  1, 0, 3'b011, 3'b000, 1, 1, 1);
        tbl[11] = mk(0, 0, 0, 3'b011, 1,  1, 0, 3'b011, 3'b000, 1, 0, 0);
        tbl[12] = mk(1, 1, 0, 3'b111, 0,  1, 1, 3'b111, 3'b111, 0, 0, 0);

        // Asynchronous reset from a running state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        m_ov = 0; m_sum = 0; m_cout = 0; m_cs = 0; m_cc = 0; m_mis = 0; m_st = 0; m_cnt = 0;
        check_model("reset");
        #5 rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            in_valid  = 1'b1;
            a         = tbl[i].a;
            b         = tbl[i].b;
            cin       = tbl[i].cin;
            fault_inj = tbl[i].fault;
            clear_err = tbl[i].clear;
            step();
            check($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d.sum", i),       32'(sum),       32'(tbl[i].e_sum));
            check($sformatf("tbl%0d.cout", i),      32'(cout),      32'(tbl[i].e_cout));
            check($sformatf("tbl%0d.core_sum", i),  32'(core_sum),  32'(tbl[i].e_cs));
            check($sformatf("tbl%0d.core_cout", i), 32'(core_cout), 32'(tbl[i].e_cc));
            check($sformatf("tbl%0d.mismatch", i),  32'(mismatch),  32'(tbl[i].e_mis));
            check($sformatf("tbl%0d.sticky", i),    32'(mismatch_sticky), 32'(tbl[i].e_st));
            check($sformatf("tbl%0d.cnt", i),       32'(mismatch_cnt),    32'(tbl[i].e_cnt));
        end

        // Valid gating: mismatching operands offered with in_valid low must be ignored
        m_ov = 1; m_sum = 1; m_cout = 1; m_cs = 3'b111; m_cc = 3'b111; m_mis = 0; m_st = 0; m_cnt = 0;
        in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0; fault_inj = 3'b011; clear_err = 1'b0;
        model_clock(1'b0, a, b, cin, fault_inj, clear_err);
        step();
        check_model("gate");

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 1'($urandom_range(0, 1));
            b         = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            fault_inj = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            clear_err = ($urandom_range(0, 15) == 0);
            model_clock(in_valid, a, b, cin, fault_inj, clear_err);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        // Counter saturation under a persistent double fault
        in_valid = 1'b0; clear_err = 1'b1;
        step();
        clear_err = 1'b0; in_valid = 1'b1;
        a = 1'b0; b = 1'b0; cin = 1'b0; fault_inj = 3'b011;
        for (int n = 0; n < 300; n++) step();
        check("sat.cnt",      32'(mismatch_cnt),    32'd255);
        check("sat.sticky",   32'(mismatch_sticky), 32'd1);
        check("sat.sum",      32'(sum),             32'd1);
        check("sat.mismatch", 32'(mismatch),        32'd1);

        // Reset asserted between edges clears everything before the next edge
        #2 rst_n = 1'b0;
        #1;
        m_ov = 0; m_sum = 0; m_cout = 0; m_cs = 0; m_cc = 0; m_mis = 0; m_st = 0; m_cnt = 0;
        check_model("midrst");
        #1 rst_n = 1'b1;
        a = 1'b1; b = 1'b1; cin = 1'b1; fault_inj = 3'b000; in_valid = 1'b1;
        model_clock(1'b1, a, b, cin, fault_inj, 1'b0);
        step();
        check_model("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
